// File: rtl/laser_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : laser_tx_framer
//  Purpose  : Drains the transmit queue into SYNC/payload/XOR-checksum packets
//             sent as 10-bit on/off-keyed frames on the laser drive line.
//  Revision : 1.0 - initial release
// ============================================================================
module laser_tx_framer #(
    parameter int         CLKS_PER_BIT = 4,
    parameter int         PKT_BYTES    = 4,
    parameter logic [7:0] SYNC         = 8'h7E
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] q_data,
    input  logic [7:0] q_size,
    input  logic       q_empty,
    output logic       q_read,
    output logic       laser_out,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int              c_CW       = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_CNT_PRE  = c_CW'(CLKS_PER_BIT - 2);
    localparam logic [5:0]      c_PKT      = 6'(PKT_BYTES);
    localparam logic [7:0]      c_PKT_SZ   = 8'(PKT_BYTES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CSUM    = 3'd3,
        S_WAIT    = 3'd4
    } state_t;

    state_t            r_state, w_state;
    logic [c_CW-1:0]   r_cnt, w_cnt;
    logic [3:0]        r_bit, w_bit;
    logic [7:0]        r_shift, w_shift;
    logic [7:0]        r_csum, w_csum;
    logic [5:0]        r_fetched, w_fetched;
    logic              r_laser, w_laser;
    logic              r_q_read, w_q_read;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic              r_underrun, w_underrun;
    logic              w_load;

    logic w_cnt_last;
    logic w_pre_fetch;
    logic w_need_fetch;

    assign w_cnt_last   = (r_cnt == c_CNT_LAST);
    assign w_pre_fetch  = (r_bit == 4'd9) && (r_cnt == c_CNT_PRE);
    assign w_need_fetch = (r_state == S_SYNC) ||
                          ((r_state == S_PAYLOAD) && (r_fetched != c_PKT));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= 4'd0;
            r_shift    <= 8'd0;
            r_csum     <= 8'd0;
            r_fetched  <= 6'd0;
            r_laser    <= 1'b0;
            r_q_read   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_bit      <= w_bit;
            r_shift    <= w_shift;
            r_csum     <= w_csum;
            r_fetched  <= w_fetched;
            r_laser    <= w_laser;
            r_q_read   <= w_q_read;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_underrun <= w_underrun;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_bit      = r_bit;
        w_shift    = r_shift;
        w_csum     = r_csum;
        w_fetched  = r_fetched;
        w_laser    = r_laser;
        w_q_read   = 1'b0;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_underrun = r_underrun;
        w_load     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && (q_size >= c_PKT_SZ)) begin
                    w_state    = S_SYNC;
                    w_busy     = 1'b1;
                    w_laser    = 1'b1;
                    w_shift    = SYNC;
                    w_bit      = 4'd0;
                    w_cnt      = '0;
                    w_csum     = 8'd0;
                    w_fetched  = 6'd0;
                    w_underrun = 1'b0;
                end
            end
            // Stalled: pop once data appears, then latch it on the following edge.
            S_WAIT: begin
                if (r_q_read) begin
                    w_load = 1'b1;
                end else if (!q_empty) begin
                    w_q_read = 1'b1;
                end
            end
            default: begin
                // The pop strobe covers the last stop-bit cycle, so raise it one edge early.
                if (w_pre_fetch && w_need_fetch && !q_empty) begin
                    w_q_read = 1'b1;
                end
                if (!w_cnt_last) begin
                    w_cnt = r_cnt + 1'b1;
                end else begin
                    w_cnt = '0;
                    if (r_bit != 4'd9) begin
                        w_bit   = r_bit + 4'd1;
                        w_laser = (r_bit == 4'd8) ? 1'b0 : r_shift[r_bit[2:0]];
                    end else begin
                        w_bit = 4'd0;
                        if (w_need_fetch) begin
                            if (r_q_read) begin
                                w_load = 1'b1;
                            end else begin
                                w_state    = S_WAIT;
                                w_underrun = 1'b1;
                                w_laser    = 1'b0;
                            end
                        end else if (r_state == S_PAYLOAD) begin
                            w_state = S_CSUM;
                            w_shift = r_csum;
                            w_laser = 1'b1;
                        end else begin
                            w_state = S_IDLE;
                            w_busy  = 1'b0;
                            w_done  = 1'b1;
                            w_laser = 1'b0;
                        end
                    end
                end
            end
        endcase

        if (w_load) begin
            w_state   = S_PAYLOAD;
            w_shift   = q_data;
            w_csum    = r_csum ^ q_data;
            w_fetched = r_fetched + 6'd1;
            w_bit     = 4'd0;
            w_cnt     = '0;
            w_laser   = 1'b1;
        end
    end

    assign q_read    = r_q_read;
    assign laser_out = r_laser;
    assign busy      = r_busy;
    assign done      = r_done;
    assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_laser_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_laser_tx_framer
//  Purpose  : Self-checking bench: queue model, line decoder and frame scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_laser_tx_framer;

    localparam int c_CPB = 4;
    localparam int c_PKT = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] q_data;
    logic [7:0] q_size;
    logic       q_empty;
    logic       q_read;
    logic       laser_out;
    logic       busy;
    logic       done;
    logic       underrun;

    laser_tx_framer #(
        .CLKS_PER_BIT (c_CPB),
        .PKT_BYTES    (c_PKT),
        .SYNC         (8'h7E)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .q_data    (q_data),
        .q_size    (q_size),
        .q_empty   (q_empty),
        .q_read    (q_read),
        .laser_out (laser_out),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Transmit queue model
    logic [7:0] fifo [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign q_data  = fifo[rd_ptr];
    assign q_size  = wr_ptr - rd_ptr;
    assign q_empty = (wr_ptr == rd_ptr);

    always @(posedge clock) if (q_read) rd_ptr <= rd_ptr + 8'd1;

    task automatic push_q(input logic [7:0] b);
        fifo[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic flush_q();
        wr_ptr = rd_ptr;
    endtask

    // Scoreboard of expected line bytes
    logic [7:0] exp_q[$];
    int         qr_log[$];
    logic       prev_qr = 1'b0;

    always @(negedge clock) begin
        if (!reset && q_read) begin
            qr_log.push_back(cyc);
            check("qread_gap", {31'd0, prev_qr}, 0);
            check("qread_nonempty", {31'd0, q_empty}, 0);
        end
        prev_qr <= q_read;
    end

    // Line decoder: a frame begins on the first 1 after idle, bits sampled mid-cell
    logic       rx_active = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_byte = 8'd0;

    always @(negedge clock) begin
        if (reset) begin
            rx_active <= 1'b0;
        end else if (!rx_active) begin
            if (laser_out) begin
                rx_active <= 1'b1;
                rx_t      <= 1;
            end
        end else begin
            rx_t <= rx_t + 1;
            if ((rx_t % c_CPB) == (c_CPB / 2)) begin
                if ((rx_t / c_CPB) >= 1 && (rx_t / c_CPB) <= 8)
                    rx_byte[(rx_t / c_CPB) - 1] <= laser_out;
                if ((rx_t / c_CPB) == 9)
                    check("rx_stop_bit", {31'd0, laser_out}, 0);
            end
            if (rx_t == 10 * c_CPB - 1) begin
                rx_active <= 1'b0;
                if (exp_q.size() == 0) check("rx_unexpected_frame", {24'd0, rx_byte}, 32'hFFFF_FFFF);
                else                   check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic expect_pkt(input logic [31:0] bytes, input logic [7:0] csum);
        exp_q.push_back(8'h7E);
        for (int i = 0; i < 4; i++) exp_q.push_back(bytes[8*i +: 8]);
        exp_q.push_back(csum);
    endtask

    task automatic load_pkt(input logic [31:0] bytes);
        for (int i = 0; i < 4; i++) push_q(bytes[8*i +: 8]);
    endtask

    task automatic launch(output int acc);
        int c0;
        c0    = cyc;
        acc   = -1;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (busy) begin
                acc = cyc;
                break;
            end
        end
        start = 1'b0;
        check("accept_latency", acc, c0 + 1);
        check("sync_start_bit", {31'd0, laser_out}, 1);
    endtask

    task automatic wait_done(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("done_timeout", 0, 1);
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 2000 && cyc < target; i++) @(negedge clock);
    endtask

    typedef struct {
        logic [31:0] bytes;
        logic [7:0]  csum;
        int          len;
    } vec_t;

    vec_t vt[4];

    initial begin
        int acc, dat, d1, d2, c0;
        logic any;

        vt[0] = '{bytes: 32'h04030201, csum: 8'h04, len: 240};
        vt[1] = '{bytes: 32'h55AA00FF, csum: 8'h00, len: 240};
        vt[2] = '{bytes: 32'h10204080, csum: 8'hF0, len: 240};
        vt[3] = '{bytes: 32'h00817E7E, csum: 8'h81, len: 240};

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", {27'd0, laser_out, q_read, busy, done, underrun}, 0);
        reset = 1'b0;

        any = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            any = any | laser_out | q_read | busy | done | underrun;
        end
        check("idle_quiet", {31'd0, any}, 0);

        // Table-driven packets
        for (int v = 0; v < 4; v++) begin
            load_pkt(vt[v].bytes);
            expect_pkt(vt[v].bytes, vt[v].csum);
            qr_log.delete();
            launch(acc);
            wait_done(400, dat);
            check("done_cycle", dat - acc, vt[v].len);
            check("busy_at_done", {31'd0, busy}, 0);
            check("qread_count", qr_log.size(), c_PKT);
            for (int n = 0; n < qr_log.size() && n < c_PKT; n++)
                check("qread_cycle", qr_log[n] - acc, (n + 1) * 10 * c_CPB - 1);
            @(negedge clock);
            check("done_one_cycle", {31'd0, done}, 0);
            repeat (3) @(negedge clock);
            check("sb_drained", exp_q.size(), 0);
        end

        // Short queue: start is held but must wait for the fourth byte
        push_q(8'h11); push_q(8'h22); push_q(8'h33);
        start = 1'b1;
        any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            any = any | busy | q_read | laser_out;
        end
        check("short_queue_ignored", {31'd0, any}, 0);
        expect_pkt(32'h44332211, 8'h44);
        push_q(8'h44);
        @(negedge clock);
        check("short_queue_then_start", {30'd0, busy, laser_out}, 2'b11);
        start = 1'b0;
        wait_done(400, dat);
        repeat (3) @(negedge clock);
        check("sb_drained_short", exp_q.size(), 0);

        // Underrun: queue emptied after two pops, refilled later
        load_pkt(32'h04030201);
        exp_q.push_back(8'h7E); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        exp_q.push_back(8'h55); exp_q.push_back(8'h0F); exp_q.push_back(8'h59);
        qr_log.delete();
        launch(acc);
        for (int i = 0; i < 200 && qr_log.size() < 2; i++) @(negedge clock);
        @(negedge clock);
        flush_q();
        wait_until(acc + 125);
        check("wait_state", {28'd0, laser_out, q_read, busy, underrun}, 4'b0011);
        repeat (20) @(negedge clock);
        check("wait_line_low", {30'd0, laser_out, busy}, 2'b01);
        push_q(8'h55); push_q(8'h0F);
        wait_done(600, dat);
        check("underrun_sticky", {31'd0, underrun}, 1);
        check("underrun_qread_count", qr_log.size(), c_PKT);
        repeat (3) @(negedge clock);
        check("sb_drained_underrun", exp_q.size(), 0);

        // start held high with 8 bytes queued: two packets, one idle cycle apart
        load_pkt(32'h08040201);
        load_pkt(32'h81402010);
        expect_pkt(32'h08040201, 8'h0F);
        expect_pkt(32'h81402010, 8'hF1);
        launch(acc);
        start = 1'b1;
        check("underrun_cleared", {31'd0, underrun}, 0);
        wait_done(400, d1);
        check("b2b_first_len", d1 - acc, 240);
        check("b2b_gap_cycle", {30'd0, busy, laser_out}, 2'b00);
        @(negedge clock);
        check("b2b_restart", {29'd0, busy, laser_out, done}, 3'b110);
        wait_done(400, d2);
        start = 1'b0;
        check("b2b_second_done", d2 - d1, 241);
        repeat (3) @(negedge clock);
        check("b2b_no_third", {31'd0, busy}, 0);
        check("sb_drained_b2b", exp_q.size(), 0);

        // Reset in the middle of payload byte 2
        load_pkt(32'h34333231);
        expect_pkt(32'h34333231, 8'h04);
        launch(acc);
        wait_until(acc + 135);
        check("frames_before_reset", exp_q.size(), 3);
        reset = 1'b1;
        @(negedge clock);
        check("reset_mid_packet", {29'd0, laser_out, q_read, busy}, 0);
        reset = 1'b0;
        exp_q.delete();
        flush_q();
        @(negedge clock);
        load_pkt(32'h44434241);
        expect_pkt(32'h44434241, 8'h04);
        launch(acc);
        wait_done(400, dat);
        check("post_reset_len", dat - acc, 240);
        repeat (3) @(negedge clock);
        check("sb_drained_post_reset", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/laser_tx_framer.md
# laser_tx_framer

Transmit framer that drains the 64-byte transmit queue and serializes its contents onto the laser drive line. On a `start` request it emits one packet: SYNC byte, `PKT_BYTES` payload bytes popped from the queue, then an XOR checksum byte. Each byte is sent as a 10-bit on/off-keyed frame. The block sits directly downstream of the transmit queue (`Q`/`read`/`empty`/`size`) and directly upstream of the laser driver pin.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per line bit, ≥2.
- `PKT_BYTES`, default 4: payload bytes per packet, 1–62.
- `SYNC`, default 8'h7E: header byte.
- `clock`  in  1: system clock. One clock domain; every register is on its rising edge.
- `reset`  in  1: synchronous, active-high reset. Reset is synchronous and active-high; no asynchronous path.
- `start`  in  1: level-sampled request to send one packet.
- `q_data`  in  8: queue head byte, combinational from the queue.
- `q_size`  in  8: queue occupancy.
- `q_empty`  in  1: queue empty flag.
- `q_read`  out  1: one-cycle pop strobe to the queue.
- `laser_out`  out  1: laser drive; 1 = on.
- `busy`  out  1: packet in progress.
- `done`  out  1: one-cycle pulse when a packet completes.
- `underrun`  out  1: sticky; set on a payload fetch with `q_empty`=1. Cleared on the next accepted `start`.

## Operation
- All outputs are registered. Reset values: `laser_out`=0, `q_read`=0, `busy`=0, `done`=0, `underrun`=0. Reset also clears the state, the counters and the checksum.
- Byte frame: start bit 1, then d[0]..d[7] (LSB first), then stop bit 0. Each bit is held `CLKS_PER_BIT` cycles. The line idles at 0.
- States and transitions:
  - IDLE → SYNC when `start`=1 and `q_size` ≥ `PKT_BYTES`. If `start`=1 with a short queue, stay in IDLE with no side effects.
  - SYNC → PAYLOAD after the SYNC frame.
  - PAYLOAD → CSUM after `PKT_BYTES` frames.
  - CSUM → IDLE after the checksum frame.
- Payload fetch happens in the last cycle of the previous frame's stop bit. In that cycle the block latches `q_data` into the shift register, XORs it into the checksum and asserts `q_read` for exactly that cycle. The queue advances on the next edge.
- Fetch with `q_empty`=1:
  - Go to WAIT, holding the line at 0 with no pop, and set `underrun`.
  - Leave WAIT when `q_empty`=0: fetch and then send the start bit.
- Checksum: 8-bit XOR of all payload bytes, initial 0. SYNC is not included.
- `start` while `busy`=1 is ignored; requests are not queued.
- `busy`=1 from the cycle after acceptance until `done`.
- Reset mid-packet: at the reset edge the line goes to 0, `q_read` deasserts and the block enters IDLE. Bytes already popped are lost.

## Timing
- `start` sampled at edge k ⇒ `busy`=1 and `laser_out`=1 (SYNC start bit) from cycle k+1.
- Packet length on the line, with no stalls: (`PKT_BYTES`+2)·10·`CLKS_PER_BIT` cycles. Defaults give 240 cycles.
- Payload byte n (n = 0…`PKT_BYTES`−1): `q_read` asserts in cycle k + (n+1)·10·`CLKS_PER_BIT`, relative to the SYNC start bit beginning at cycle k+1.
- No inter-byte gap: a stop bit is followed immediately by the next start bit.
- `done` pulses in the cycle after the final stop-bit cycle. At the same edge `busy` drops to 0.
- A `start` sampled at the same edge that `done` is registered is ignored. The earliest accepted restart is the following edge.
- A bit-cycle counter of width $clog2(`CLKS_PER_BIT`) wraps at `CLKS_PER_BIT`−1. A 4-bit bit index runs 0..9.
- Exactly `PKT_BYTES` `q_read` pulses per completed packet, never two in consecutive cycles.

## Test plan
- Reset, then idle 50 cycles → every output stays 0 and `q_read` never asserts.
- Queue holds 01,02,03,04; `start` pulse (defaults) → line shows frames 7E,01,02,03,04,04. Four `q_read` pulses at the computed cycles. `done` at cycle 241 after acceptance.
- `q_size`=3, `start`=1 → no state change and no `q_read`. Then `q_size`=4 → packet begins the cycle after.
- Empty the queue after 2 payload pops → WAIT, line 0, `underrun`=1. Refill with 0x55 → frame 55 resumes. Checksum = XOR of the 4 bytes actually sent.
- `start` held high continuously with 8 bytes queued → two back-to-back packets, one idle cycle between `done` and the next SYNC start bit, `busy` low for that one cycle.
- Assert `reset` during payload byte 2 → next cycle `laser_out`=0, `q_read`=0, `busy`=0. A later `start` sends a fresh SYNC with the checksum restarted at 0.
